// File: rtl/friet_permutation_job_sequencer.sv
// Two-channel round-robin job sequencer in front of one Friet permutation core.
// Latency: 1 grant + WORDS load + 1 start + core latency + 1 finish capture + WORDS drain cycles.
// Backpressure: req_valid low stalls loading, resp_ready low freezes the drain (no shift-out).
//
// Ports:
//   clk, rst                      : single clock, synchronous active-high reset
//   req{0,1}_data/valid/ready     : per-channel input word streams (12 words per job)
//   resp{0,1}_data/valid/ready    : per-channel result streams, with _last marker and _fault tag
//   perm_*                        : start pulse, shift-in/out strobes and status of the core
//   busy, owner                   : job in flight, channel currently holding the grant
module friet_permutation_job_sequencer #(
  parameter int WORDS          = 12,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TIMER_WIDTH    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  output logic [31:0] resp0_data,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp0_last,
  output logic        resp0_fault,
  input  logic [31:0] req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [31:0] resp1_data,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic        resp1_last,
  output logic        resp1_fault,
  output logic        perm_start_enable,
  output logic        perm_state_buffer_in_enabled,
  output logic [31:0] perm_state_buffer_in,
  output logic        perm_state_buffer_out_enabled,
  input  logic [31:0] perm_state_word,
  input  logic        perm_core_free,
  input  logic        perm_core_finish,
  input  logic        perm_fault_detected,
  output logic        busy,
  output logic        owner
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0]          LAST_CNT = CW'(WORDS - 1);
  localparam logic [TIMER_WIDTH-1:0] TMO_CNT  = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TMR_MAX  = '1;

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   fault_lat_q, fault_lat_d;
  logic                   timeout_lat_q, timeout_lat_d;

  // Shared (channel-agnostic) stream signals, steered to the granted channel below.
  logic        in_rdy;
  logic        out_vld;
  logic [31:0] out_dat;
  logic        out_last;
  logic        out_fault;

  logic        req_valid_g;
  logic [31:0] req_data_g;
  logic        resp_ready_g;

  assign req_valid_g  = grant_q ? req1_valid  : req0_valid;
  assign req_data_g   = grant_q ? req1_data   : req0_data;
  assign resp_ready_g = grant_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    fault_lat_d   = fault_lat_q;
    timeout_lat_d = timeout_lat_q;

    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    out_dat   = '0;
    out_last  = 1'b0;
    out_fault = 1'b0;

    perm_start_enable             = 1'b0;
    perm_state_buffer_in_enabled  = 1'b0;
    perm_state_buffer_in          = '0;
    perm_state_buffer_out_enabled = 1'b0;

    case (state_q)
      IDLE: begin
        if (perm_core_free && (req0_valid || req1_valid)) begin
          // Prefer the channel that did not complete the previous job.
          if (last_grant_q) grant_d = req0_valid ? 1'b0 : 1'b1;
          else              grant_d = req1_valid ? 1'b1 : 1'b0;
          cnt_d         = '0;
          fault_lat_d   = 1'b0;
          timeout_lat_d = 1'b0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        in_rdy               = 1'b1;
        perm_state_buffer_in = req_data_g;
        if (req_valid_g) begin
          perm_state_buffer_in_enabled = 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      START: begin
        perm_start_enable = 1'b1;
        timer_d           = '0;
        state_d           = WAIT;
      end
      WAIT: begin
        // Saturating so a stuck core can never wrap the watchdog past its abort point.
        timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + TIMER_WIDTH'(1);
        if (perm_core_finish) begin
          fault_lat_d = perm_fault_detected;
          state_d     = DRAIN;
        end else if (timer_q >= TMO_CNT) begin
          timeout_lat_d = 1'b1;
          state_d       = DRAIN;
        end
      end
      DRAIN: begin
        out_vld   = 1'b1;
        // After an abort the core state is meaningless; return zeros and leave the core alone.
        out_dat   = timeout_lat_q ? 32'h0 : perm_state_word;
        out_fault = fault_lat_q | timeout_lat_q;
        out_last  = (cnt_q == LAST_CNT);
        if (resp_ready_g) begin
          perm_state_buffer_out_enabled = ~timeout_lat_q;
          if (cnt_q == LAST_CNT) begin
            cnt_d        = '0;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      timer_q       <= '0;
      fault_lat_q   <= 1'b0;
      timeout_lat_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      fault_lat_q   <= fault_lat_d;
      timeout_lat_q <= timeout_lat_d;
    end
  end

  // Non-granted channel is held fully quiet.
  assign req0_ready  = in_rdy & ~grant_q;
  assign req1_ready  = in_rdy &  grant_q;
  assign resp0_valid = out_vld & ~grant_q;
  assign resp1_valid = out_vld &  grant_q;
  assign resp0_last  = out_last & ~grant_q;
  assign resp1_last  = out_last &  grant_q;
  assign resp0_fault = out_fault & ~grant_q;
  assign resp1_fault = out_fault &  grant_q;
  assign resp0_data  = grant_q ? 32'h0 : out_dat;
  assign resp1_data  = grant_q ? out_dat : 32'h0;

  assign busy  = (state_q != IDLE);
  assign owner = grant_q;

endmodule

// File: doc/friet_permutation_job_sequencer.md
# friet_permutation_job_sequencer

Two-channel job scheduler and sequencer in front of one protected Friet permutation core (`friet_permutation_protected_n_rounds_no_communication`, BUFFER_LENGTH=32). It runs the following sequence for one job at a time:

- picks a requester by round-robin;
- streams 12 input words into the core's state buffer;
- starts the permutation and waits for completion, with a watchdog;
- streams 12 result words back to the owning channel, tagged with the core's fault flag.

It sits between the crypto mode engines and the permutation core. It replaces direct register-level access to the core.

## Interface
Parameters:
- `WORDS`, 12: 32-bit words per 384-bit state; load and drain length.
- `TIMEOUT_CYCLES`, 1023: maximum cycles in WAIT before the job is aborted.
- `TIMER_WIDTH`, 10: must satisfy `TIMEOUT_CYCLES < 2^TIMER_WIDTH`.

Ports, one per line as name / direction / width / meaning:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req0_data` in 32, `req0_valid` in 1, `req0_ready` out 1: channel 0 input word stream.
- `resp0_data` out 32, `resp0_valid` out 1, `resp0_ready` in 1: channel 0 result word stream.
- `resp0_last` out 1, `resp0_fault` out 1: channel 0 last-word marker and fault tag.
- `req1_*`, `resp1_*`: identical set for channel 1.
- `perm_start_enable` out 1: core start pulse.
- `perm_state_buffer_in_enabled` out 1: core shift-in strobe.
- `perm_state_buffer_in` out 32: core input word.
- `perm_state_buffer_out_enabled` out 1: core shift-out strobe.
- `perm_state_word` in 32: core `state_buffer[31:0]`.
- `perm_core_free` in 1: core idle.
- `perm_core_finish` in 1: core done pulse.
- `perm_fault_detected` in 1: core fault flag.
- `busy` out 1: high whenever state ≠ IDLE.
- `owner` out 1: currently granted channel.

## Operation
States: IDLE, LOAD, START, WAIT, DRAIN. Registers:
- `grant`, `last_grant` (reset value 1, so channel 0 wins first);
- word counter (0..WORDS-1), watchdog timer;
- `fault_lat`, `timeout_lat`.

State behaviour:
- **IDLE**: when `perm_core_free`=1 and any `reqN_valid`=1:
  - grant goes to the channel ≠ `last_grant` if it is requesting, otherwise to the requesting channel;
  - `grant` is registered, counter cleared, `fault_lat`/`timeout_lat` cleared, next state LOAD.
- **LOAD**:
  - `req[grant]_ready`=1; the other channel's ready is 0.
  - On each handshake: `perm_state_buffer_in_enabled`=1 in the same cycle, `perm_state_buffer_in`=`req[grant]_data`, counter increments.
  - The handshake at counter=WORDS-1 moves to START and clears the counter.
  - When `req_valid` is low, nothing shifts and the counter holds.
- **START**: `perm_start_enable`=1 for exactly one cycle; timer cleared; next state WAIT.
- **WAIT**: timer increments each cycle.
  - On `perm_core_finish`=1: `fault_lat`←`perm_fault_detected`, next state DRAIN.
  - Otherwise, when timer=TIMEOUT_CYCLES-1: `timeout_lat`←1, next state DRAIN.
  - If finish and timeout occur in the same cycle, finish wins.
- **DRAIN**:
  - `resp[grant]_valid`=1.
  - `resp_data`=`perm_state_word` normally; 32'h0 if `timeout_lat`.
  - `resp_fault`=`fault_lat | timeout_lat`, constant for all WORDS words.
  - `resp_last`=1 only at counter=WORDS-1.
  - On each handshake: counter increments, and `perm_state_buffer_out_enabled`=1 in the same cycle unless `timeout_lat`.
  - The last handshake sets `last_grant`←`grant` and moves to IDLE.
- Channel isolation: the non-granted channel sees `req_ready`=0 and `resp_valid`=0/`resp_last`=0/`resp_fault`=0 at all times.
- Core strobes are mutually exclusive and are never asserted in IDLE.

## Timing
- Reset values:
  - all `req_ready`, `resp_valid`, `resp_last`, `resp_fault`, `resp_data`, and all `perm_*` outputs are 0;
  - `busy`=0, `owner`=0.
  - Registers: `last_grant`=1, counter=0, timer=0, state IDLE.
- `rst` asserted mid-job:
  - the next cycle is IDLE with all strobes low;
  - the core is not reset by this block;
  - no grant is issued until `perm_core_free`=1.
- Grant latency: `req_valid` sampled high in IDLE at cycle t gives `req_ready`=1 at t+1.
- `req_ready`, `resp_valid`, `resp_data` and `resp_last` are combinational from state/grant/counter/`perm_state_word` (no input-to-output combinational path from `resp_ready`).
- `perm_state_buffer_in` is combinational from the granted channel's `req_data`.
- Back-pressure: with `resp_ready`=0, `resp_valid` and `resp_data` hold stable (no shift-out).
- Minimum job length: 1 (grant) + WORDS (load) + 1 (start) + core latency + 1 (finish capture) + WORDS (drain) cycles.
- The timer saturates, and the abort cannot be missed.

## Test plan
- **Single job, ch0**: 12 words 0..11 streamed back-to-back.
  - Expected: 12 in-strobes on consecutive cycles, then one `perm_start_enable` pulse.
  - After finish, 12 result words with `resp0_last` on word 11 and `resp0_fault`=0; `busy` low afterwards.
- **Round-robin**: both channels requesting continuously from reset.
  - Expected grant order ch0, ch1, ch0, ch1.
  - The idle channel never sees ready or valid.
- **Fault**: core asserts `perm_fault_detected`=1 with finish.
  - Expected: all 12 result words have `resp_fault`=1.
- **Watchdog**: `perm_core_finish` never asserts.
  - Expected: DRAIN exactly TIMEOUT_CYCLES cycles after START.
  - 12 zero words with `resp_fault`=1 and no out-strobes.
- **Stalls**:
  - `req_valid` toggling 1010 during load: exactly 12 in-strobes.
  - `resp_ready` low for 5 cycles mid-drain: data held and no out-strobe while stalled.
- **Reset mid-WAIT**: `rst` for 1 cycle.
  - Expected: IDLE next cycle, all outputs at reset values.
  - The next grant waits for `perm_core_free`=1 and goes to ch0.
